// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts max(prescale, 1) clocks; all inputs are captured when a frame is accepted.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int              BIT_W    = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]            state_q,   state_d;
  logic [BIT_W-1:0]      bit_q,     bit_d;
  logic [PRESCALE_W-1:0] cnt_q,     cnt_d;
  logic [PRESCALE_W-1:0] reload_q,  reload_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;

  logic cnt_done;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path through the case infers a latch.
    state_d   = state_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
          // The parity bit is fixed at capture, so later input changes cannot reach it.
          shift_d   = p_data;
          par_en_d  = par_en;
          par_bit_d = (^p_data) ^ par_typ;
          reload_d  = (prescale == '0) ? '0 : prescale - 1'b1;
          cnt_d     = (prescale == '0) ? '0 : prescale - 1'b1;
          bit_d     = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      S_START: begin
        if (cnt_done) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          cnt_d   = reload_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_done) begin
          cnt_d = reload_q;
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = reload_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_done) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge value of the others.
    if (rst) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      cnt_q     <= '0;
      reload_q  <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table of frames checked cycle by cycle
// against a queue of expected {tx_out, busy} samples, plus hand-written reset sequences.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [1:0] mon_exp;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
    logic       exp_par;
    int         mode;   // 0 plain, 1 change prescale/data mid-frame, 2 data_valid pulse while busy
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .prescale  (prescale),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: {tx_out,busy} = %b, expected %b", name, $time, got, want);
    end
  endtask

  // Idle line ({tx_out,busy} = 2'b10) is expected whenever no frame sample is pending.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else                  mon_exp = 2'b10;
      check("stream", {tx_out, busy}, mon_exp);
    end
  end

  task automatic push_bit(input logic b, input int p);
    repeat (p) exp_q.push_back({b, 1'b1});
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par, input int p);
    push_bit(1'b0, p);
    for (int i = 0; i < 8; i++) push_bit(d[i], p);
    if (pe) push_bit(par, p);
    push_bit(1'b1, p);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: %0d expected samples never consumed, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input vec_t v);
    int p;
    p = (v.ps == 6'd0) ? 1 : int'(v.ps);
    @(posedge clk); #1;
    p_data     = v.data;
    par_en     = v.pe;
    par_typ    = v.pt;
    prescale   = v.ps;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    push_frame(v.data, v.pe, v.exp_par, p);
    if (v.mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      prescale = 6'd8;
      p_data   = 8'hFF;
      par_en   = ~v.pe;
      par_typ  = ~v.pt;
    end else if (v.mode == 2) begin
      repeat (3) @(posedge clk);
      #1;
      p_data     = ~v.data;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
    drain("frame");
    repeat (4) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd1, 1'b0, 0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd1, 1'b0, 0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd1, 1'b1, 0};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 6'd1, 1'b1, 0};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 6'd1, 1'b0, 0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 6'd4, 1'b0, 1};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 6'd1, 1'b0, 2};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 6'd0, 1'b1, 0};
    vecs[8] = '{8'h81, 1'b1, 1'b0, 6'd3, 1'b0, 0};

    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset", {tx_out, busy}, 2'b10);

    // Five idle cycles are checked by the monitor with an empty queue.
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    foreach (vecs[i]) run_frame(vecs[i]);

    // data_valid held high: each frame is followed by exactly one idle cycle.
    @(posedge clk); #1;
    p_data     = 8'h55;
    par_en     = 1'b0;
    prescale   = 6'd1;
    data_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #1;
      push_frame(8'h55, 1'b0, 1'b0, 1);
      if (f < 2) begin
        exp_q.push_back(2'b10);
        repeat (10) @(posedge clk);
      end else begin
        data_valid = 1'b0;
      end
    end
    drain("back_to_back");
    repeat (4) @(posedge clk);

    // Reset during DATA bit 3 abandons the frame.
    mon_en = 1'b0;
    @(posedge clk); #1;
    p_data     = 8'hA5;
    par_en     = 1'b0;
    prescale   = 6'd1;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check("start_before_reset", {tx_out, busy}, 2'b01);
    repeat (4) @(posedge clk);
    #1;
    check("data_bit3", {tx_out, busy}, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_frame_reset", {tx_out, busy}, 2'b10);
    @(posedge clk); #1;
    check("after_reset_idle", {tx_out, busy}, 2'b10);

    // Reset and data_valid together: reset wins.
    rst        = 1'b1;
    data_valid = 1'b1;
    p_data     = 8'hFF;
    @(posedge clk); #1;
    rst        = 1'b0;
    data_valid = 1'b0;
    check("rst_with_valid", {tx_out, busy}, 2'b10);
    @(posedge clk); #1;
    check("rst_with_valid_next", {tx_out, busy}, 2'b10);

    mon_en = 1'b1;
    run_frame('{8'hA5, 1'b1, 1'b1, 6'd2, 1'b1, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter, the transmit-side counterpart of the UART receive path (start check, data sampling, parity/stop check) in the same system.
- Accepts a parallel word, then serializes it: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Sits in the UART TX clock domain, fed by the system controller or a synchronizing FIFO.
- Bit period is programmable in clock cycles, so the block runs off the shared UART clock.

Parameters:
- DATA_WIDTH, 8, width of the payload word; legal range 5..9.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- clk  input  1  UART TX clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- p_data  input  DATA_WIDTH  parallel payload.
- data_valid  input  1  request to transmit p_data.
- par_en  input  1  1 = append a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_W  clock cycles per bit; 0 is treated as 1.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress; data_valid is ignored while high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - next cycle: tx_out=1, busy=0, state=IDLE, bit counter=0, prescale counter=0, captured registers=0.
  - Applies mid-frame with no completion; the partial frame is abandoned.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If data_valid=1 at edge k, capture p_data, par_en, par_typ and prescale, and go to START.
  - Inputs are not re-sampled until the frame ends; later changes do not affect the frame in flight.
- Latency: the start bit (tx_out=0) and busy=1 appear at cycle k+1.
- Bit timing:
  - each bit is held for P = max(captured prescale, 1) cycles via a down-counter.
  - the state advances when the counter expires.
- START: tx_out=0 for P cycles, then DATA.
- DATA:
  - tx_out = data bit i, i = 0..DATA_WIDTH-1, LSB first, P cycles each.
  - after bit DATA_WIDTH-1: go to PARITY if par_en, else STOP.
- PARITY:
  - tx_out = XOR of all captured data bits, XOR par_typ; held for P cycles.
  - i.e. even: number of ones including the parity bit is even; odd: that number is odd.
- STOP: tx_out=1 for P cycles, then IDLE.
- busy is 1 from the first start-bit cycle through the last stop-bit cycle inclusive, and 0 in IDLE.
- Frame length is P × (DATA_WIDTH + 2 + par_en) cycles.
- Back-to-back frames:
  - data_valid held high through a frame does not start a new frame until the block is in IDLE.
  - minimum inter-frame gap is one IDLE cycle (tx_out=1, busy=0); a new frame's start bit appears the cycle after.
- data_valid=1 while busy=1: ignored, not queued.
- Simultaneous rst=1 and data_valid=1: reset wins; no frame starts.
- prescale changed mid-frame: no effect until the next acceptance.
- Parity computation is purely from captured data; par_en=0 drops the PARITY state entirely.

Test Plan:
- Reset, then idle 5 cycles with data_valid=0 -> tx_out=1, busy=0 throughout.
- prescale=1, par_en=0, p_data=0xA5, data_valid pulse at cycle k:
  - tx_out from k+1 = 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
  - busy=1 for exactly 10 cycles, then 0.
- prescale=1, par_en=1, p_data=0xA5:
  - par_typ=0 -> parity bit 0; par_typ=1 -> parity bit 1; 11-cycle frame.
  - repeat with 0x07: even -> parity bit 1, odd -> parity bit 0.
- prescale=4, par_en=0, p_data=0x3C:
  - each bit held 4 cycles; frame = 40 cycles.
  - changing prescale to 8 and p_data to 0xFF mid-frame does not alter the frame.
- data_valid held high continuously with prescale=1, p_data=0x55:
  - frames repeat with exactly one idle-high cycle between each stop bit and the next start bit.
  - a pulse during busy=1 with a different p_data value is never transmitted.
- rst asserted for one cycle during DATA bit 3 of a frame:
  - next cycle tx_out=1, busy=0.
  - a new data_valid afterwards produces a complete, correct frame.
